digit_serial_adder: RTL and testbench
=====================================

Name: digit_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor that processes DIGIT bits per clock, LSB digit first, with a carry register chaining the digits. It is the sequential, width-generic successor to the team's 4-bit ripple full adder. It trades latency for area in wide datapaths and adds subtract mode, a Start/Done handshake and signed overflow detection. It sits between operand registers and any consumer that can tolerate WIDTH/DIGIT cycles of latency.

Parameters:
WIDTH, 16, operand and result width in bits; must be an integer multiple of DIGIT.
DIGIT, 4, bits added per clock cycle; 1 <= DIGIT <= WIDTH.

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
Start  input  1  request a new operation; accepted only in IDLE or DONE state.
Sub  input  1  0 = add, 1 = subtract (A - B); sampled with Start.
CIn  input  1  carry-in for add mode; sampled with Start; ignored when Sub=1.
A  input  WIDTH  operand A; sampled with Start.
B  input  WIDTH  operand B; sampled with Start.
Busy  output  1  high while an operation is in progress (RUN state).
Done  output  1  one-cycle pulse when S/COut/Ovf become valid.
S  output  WIDTH  result, registered.
COut  output  1  carry out of bit WIDTH-1; in subtract mode 1 = no borrow.
Ovf  output  1  two's-complement overflow flag.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; Busy=0, Done=0, S=0, COut=0, Ovf=0; internal operand, carry and digit counter cleared. Reset overrides every other input, including mid-operation; the aborted operation produces no Done.
- N = WIDTH/DIGIT digit cycles per operation.
- States:
  - IDLE: Busy=0. Start=1 moves to RUN.
  - RUN: Busy=1 for exactly N cycles. After the N-th digit, moves to DONE.
  - DONE: lasts one cycle, with Done=1. Start=1 moves to RUN (back-to-back operation); otherwise moves to IDLE.
- Start handling: Start is ignored while in RUN; inputs are not re-sampled and the current operation is unaffected.
- Operand capture on accepted Start:
  - Aop = A.
  - Bop = Sub ? ~B : B.
  - carry = Sub ? 1 : CIn.
  - digit counter = 0.
- Each RUN cycle k (k = 0..N-1):
  - Computes {c, d} = Aop[k*DIGIT +: DIGIT] + Bop[k*DIGIT +: DIGIT] + carry.
  - Stores d into the internal result at slice k and sets carry = c.
  - On the final digit, also records the carry into bit WIDTH-1 (needed for Ovf).
- Output update:
  - S, COut and Ovf update only on the cycle Done rises.
  - They hold their values until the next Done or reset.
  - They never show partial results.
- Result definitions:
  - S = (Aop + Bop + carry0) mod 2^WIDTH.
  - COut = final carry.
  - Ovf = (carry into bit WIDTH-1) XOR COut.
- Latency: Start sampled at edge t gives Done=1 during the cycle after edge t+N. For example, with WIDTH=16 and DIGIT=4, Busy is high for 4 cycles and then Done is high for 1 cycle.
- Degenerate case: DIGIT=WIDTH gives N=1, so Busy is high for 1 cycle and then Done follows.
- Throughput: with Start held high continuously, one result every N+1 cycles.
- No combinational path exists from any input to any output.

Test Plan:
1. WIDTH=16, DIGIT=4, Sub=0, CIn=0, A=0x1234, B=0x4321, pulse Start -> Busy high for 4 cycles, Done pulses once, S=0x5555, COut=0, Ovf=0.
2. Sub=0, CIn=0, A=0xFFFF, B=0x0001 -> S=0x0000, COut=1, Ovf=0. Then A=0x7FFF, B=0x0001 -> S=0x8000, COut=0, Ovf=1. Also A=0x0000, B=0x0000, CIn=1 -> S=0x0001, COut=0, Ovf=0.
3. Sub=1, CIn=1 (must be ignored), A=0x0005, B=0x0007 -> S=0xFFFE, COut=0, Ovf=0. Then A=0x8000, B=0x0001 -> S=0x7FFF, COut=1, Ovf=1.
4. Start re-asserted with different operands during RUN -> ignored; the first result is unchanged. Start held high through DONE -> second operation begins immediately, with Done pulses exactly 5 cycles apart.
5. rst_n=0 during the 2nd RUN cycle -> next cycle Busy=0 and S, COut, Ovf are 0; no Done pulse. A following Start yields a correct result.
6. Parameter sweep DIGIT in {1, 2, 4, 16} with WIDTH=16, 1000 random operands per DIGIT value, both modes -> S/COut/Ovf match the reference model, and latency is N cycles of Busy followed by 1 cycle of Done.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB digit first, carry chained in a register.
// Start/Done handshake; S/COut/Ovf are registered and change only as Done rises.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic             CIn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             COut,
  output logic             Ovf
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_aop;
  logic [WIDTH-1:0] r_bop;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;
  logic [DIGIT:0]   w_sum;
  logic             w_msb_cin;
  logic             w_last;
  logic             w_accept;

  // Operands shift right each cycle, so the current digit is always in the low DIGIT bits.
  always_comb begin
    w_sum      = {1'b0, r_aop[DIGIT-1:0]} + {1'b0, r_bop[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};
    // Carry into the digit MSB, recovered from the sum bit and its two addend bits.
    w_msb_cin  = w_sum[DIGIT-1] ^ r_aop[DIGIT-1] ^ r_bop[DIGIT-1];
    w_res_next = r_res;
    w_res_next[r_cnt*DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
    w_last     = (r_cnt == CntW'(N - 1));
    w_accept   = Start && (r_state != StRun);
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (Start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = Start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_aop   <= '0;
      r_bop   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      S       <= '0;
      COut    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_aop   <= A;
        r_bop   <= Sub ? ~B : B;
        r_carry <= Sub | CIn;
        r_res   <= '0;
        r_cnt   <= '0;
      end else if (r_state == StRun) begin
        r_aop   <= r_aop >> DIGIT;
        r_bop   <= r_bop >> DIGIT;
        r_carry <= w_sum[DIGIT];
        r_res   <= w_res_next;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          S    <= w_res_next;
          COut <= w_sum[DIGIT];
          Ovf  <= w_msb_cin ^ w_sum[DIGIT];
        end
      end
    end
  end

  assign Busy = (r_state == StRun);
  assign Done = (r_state == StDone);

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and randomised checks of digit_serial_adder for DIGIT = 1, 2, 4, 16 at WIDTH = 16.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [4];
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy  [4];
  logic        done  [4];
  logic [15:0] s     [4];
  logic        cout  [4];
  logic        ovf   [4];

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    digit_serial_adder #(.WIDTH(16), .DIGIT(D)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .Start(start[g]),
      .Sub  (sub),
      .CIn  (cin),
      .A    (a),
      .B    (b),
      .Busy (busy[g]),
      .Done (done[g]),
      .S    (s[g]),
      .COut (cout[g]),
      .Ovf  (ovf[g])
    );
  end

  // One Start pulse, then count Busy cycles until Done; ndone also counts a too-long Done.
  task automatic run_op(input int idx, input logic op_sub, input logic op_cin,
                        input logic [15:0] op_a, input logic [15:0] op_b,
                        output int nbusy, output int ndone,
                        output logic [15:0] rs, output logic rc, output logic ro);
    nbusy = 0;
    ndone = 0;
    rs    = '0;
    rc    = 1'b0;
    ro    = 1'b0;
    @(negedge clk);
    start[idx] = 1'b1;
    sub = op_sub;
    cin = op_cin;
    a   = op_a;
    b   = op_b;
    @(negedge clk);
    start[idx] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done[idx]) begin
        ndone++;
        rs = s[idx];
        rc = cout[idx];
        ro = ovf[idx];
        break;
      end
      if (busy[idx]) nbusy++;
      @(negedge clk);
    end
    if (ndone == 1) begin
      @(negedge clk);
      if (done[idx]) ndone++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      n_vec++;
      if ({busy[g], done[g], s[g], cout[g], ovf[g]} !== 20'h0) begin
        n_err++;
        $display("FAIL reset[%0d]: busy=%b done=%b s=%h c=%b o=%b, required all 0",
                 g, busy[g], done[g], s[g], cout[g], ovf[g]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    vec_t v [4];
    int nb, nd;
    logic [15:0] rs;
    logic rc, ro;
    v[0] = {1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    v[1] = {1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    v[2] = {1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    v[3] = {1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_op(2, v[i].sub, v[i].cin, v[i].a, v[i].b, nb, nd, rs, rc, ro);
      n_vec++;
      if (nb !== 4 || nd !== 1) begin
        n_err++;
        $display("FAIL add_latency[%0d]: busy=%0d done=%0d, required 4 and 1", i, nb, nd);
      end
      n_vec++;
      if ({rs, rc, ro} !== {v[i].s, v[i].c, v[i].o}) begin
        n_err++;
        $display("FAIL add_result[%0d]: s=%h c=%b o=%b, required s=%h c=%b o=%b",
                 i, rs, rc, ro, v[i].s, v[i].c, v[i].o);
      end
    end
  endtask

  task automatic test_sub();
    vec_t v [2];
    int nb, nd;
    logic [15:0] rs;
    logic rc, ro;
    v[0] = {1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    v[1] = {1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    for (int i = 0; i < 2; i++) begin
      run_op(2, v[i].sub, v[i].cin, v[i].a, v[i].b, nb, nd, rs, rc, ro);
      n_vec++;
      if (nb !== 4 || nd !== 1) begin
        n_err++;
        $display("FAIL sub_latency[%0d]: busy=%0d done=%0d, required 4 and 1", i, nb, nd);
      end
      n_vec++;
      if ({rs, rc, ro} !== {v[i].s, v[i].c, v[i].o}) begin
        n_err++;
        $display("FAIL sub_result[%0d]: s=%h c=%b o=%b, required s=%h c=%b o=%b",
                 i, rs, rc, ro, v[i].s, v[i].c, v[i].o);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] rs = '0;
    int nd = 0;
    @(negedge clk);
    start[2] = 1'b1;
    sub = 1'b0;
    cin = 1'b0;
    a = 16'h1111;
    b = 16'h2222;
    @(negedge clk);
    start[2] = 1'b0;
    @(negedge clk);
    start[2] = 1'b1;
    a = 16'hAAAA;
    b = 16'h5555;
    @(negedge clk);
    start[2] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done[2]) begin
        nd++;
        rs = s[2];
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (nd !== 1 || rs !== 16'h3333) begin
      n_err++;
      $display("FAIL start_ignored: done=%0d s=%h, required done=1 s=3333", nd, rs);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1;
    logic [15:0] s1 = '0, s2 = '0;
    @(negedge clk);
    start[2] = 1'b1;
    sub = 1'b0;
    cin = 1'b0;
    a = 16'h1000;
    b = 16'h0234;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done[2]) begin
        if (t1 < 0) begin
          t1 = i;
          s1 = s[2];
          a  = 16'h2000;
        end else begin
          t2 = i;
          s2 = s[2];
          start[2] = 1'b0;
          break;
        end
      end
    end
    start[2] = 1'b0;
    n_vec++;
    if (t1 < 0 || t2 < 0 || (t2 - t1) !== 5) begin
      n_err++;
      $display("FAIL b2b_spacing: done at %0d and %0d, required 5 apart", t1, t2);
    end
    n_vec++;
    if (s1 !== 16'h1234 || s2 !== 16'h2234) begin
      n_err++;
      $display("FAIL b2b_result: s1=%h s2=%h, required 1234 and 2234", s1, s2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nb, nd;
    int late_done = 0;
    logic [15:0] rs;
    logic rc, ro;
    @(negedge clk);
    start[2] = 1'b1;
    sub = 1'b0;
    cin = 1'b0;
    a = 16'h0F0F;
    b = 16'h0101;
    @(negedge clk);
    start[2] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy[2] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_busy: busy=%b, required 1", busy[2]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if ({busy[2], done[2], s[2], cout[2], ovf[2]} !== 20'h0) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b done=%b s=%h c=%b o=%b, required all 0",
               busy[2], done[2], s[2], cout[2], ovf[2]);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done[2]) late_done++;
    end
    n_vec++;
    if (late_done !== 0) begin
      n_err++;
      $display("FAIL mid_no_done: %0d Done cycles, required 0", late_done);
    end
    run_op(2, 1'b0, 1'b0, 16'h0F0F, 16'h0101, nb, nd, rs, rc, ro);
    n_vec++;
    if (nb !== 4 || nd !== 1 || {rs, rc, ro} !== {16'h1010, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL mid_recover: busy=%0d done=%0d s=%h c=%b o=%b, required 4 1 1010 0 0",
               nb, nd, rs, rc, ro);
    end
  endtask

  task automatic test_sweep();
    int nb, nd, n;
    logic [15:0] rs, op_a, op_b, bop, es;
    logic rc, ro, op_sub, op_cin, ec, eo;
    logic [16:0] sum;
    for (int g = 0; g < 4; g++) begin
      n = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 4 : 1;
      for (int i = 0; i < 1000; i++) begin
        op_a   = 16'($urandom);
        op_b   = 16'($urandom);
        op_sub = 1'($urandom_range(0, 1));
        op_cin = 1'($urandom_range(0, 1));
        bop = op_sub ? ~op_b : op_b;
        sum = {1'b0, op_a} + {1'b0, bop} + {16'h0, (op_sub | op_cin)};
        es  = sum[15:0];
        ec  = sum[16];
        eo  = (op_a[15] == bop[15]) && (es[15] != op_a[15]);
        run_op(g, op_sub, op_cin, op_a, op_b, nb, nd, rs, rc, ro);
        n_vec++;
        if (nb !== n || nd !== 1) begin
          n_err++;
          $display("FAIL sweep_latency[%0d]: busy=%0d done=%0d, required %0d and 1",
                   g, nb, nd, n);
        end
        n_vec++;
        if ({rs, rc, ro} !== {es, ec, eo}) begin
          n_err++;
          $display("FAIL sweep_result[%0d]: %h %s %h -> s=%h c=%b o=%b, required s=%h c=%b o=%b",
                   g, op_a, op_sub ? "-" : "+", op_b, rs, rc, ro, es, ec, eo);
        end
      end
    end
  endtask

  initial begin
    for (int g = 0; g < 4; g++) start[g] = 1'b0;
    rst_n = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_add();
    test_sub();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
